// File: rtl/demux18_8b_buf.sv
// -----------------------------------------------------------------------------
// demux18_8b_buf
//   One-to-eight byte demultiplexer. Each output lane holds a single-entry
//   buffer: an 8-bit data register and a valid flag. An upstream beat is sent
//   to the lane chosen by in_sel. A lane can accept a new byte in the same
//   cycle that its consumer takes the old one, so each lane runs at full rate.
//   out_cnt is a registered count of the occupied lanes.
//
//   Optional build macro: DEMUX_BCAST_EN
//     When defined, the in_bcast input is added. A beat accepted with
//     in_bcast=1 is written into all eight lanes, and in_sel is ignored.
//     The beat is only accepted when every lane is free.
//     When the macro is not defined, the port is absent and the block always
//     behaves as unicast.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   en         in   global enable; gates acceptance only, lanes still drain
//   in_data    in   byte to distribute
//   in_sel     in   destination lane index 0..7
//   in_valid   in   upstream beat present
//   in_bcast   in   broadcast request (only with DEMUX_BCAST_EN)
//   in_ready   out  beat accepted when in_valid & in_ready
//   out_data   out  lane k data on [8k+7:8k]
//   out_valid  out  lane k holds an undelivered byte
//   out_ready  in   lane k consumer takes the byte this cycle
//   out_cnt    out  number of occupied lanes, 0..8
// -----------------------------------------------------------------------------
module demux18_8b_buf #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [2:0]            in_sel,
  input  logic                  in_valid,
`ifdef DEMUX_BCAST_EN
  input  logic                  in_bcast,
`endif
  output logic                  in_ready,
  output logic [8*DATA_W-1:0]   out_data,
  output logic [7:0]            out_valid,
  input  logic [7:0]            out_ready,
  output logic [3:0]            out_cnt
);

  localparam int LANES = 8;

  // Number of set bits in a lane mask.
  function automatic logic [3:0] popcnt8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {3'd0, m[i]};
    end
    return c;
  endfunction

  // Lane state: registered data, valid flag and occupancy count
  logic [DATA_W-1:0] data_p1 [LANES];
  logic [7:0]        vld_p1;
  logic [3:0]        cnt_p1;

  // Combinational decisions taken in the current cycle
  logic              bcast_p0;
  logic [7:0]        free_p0;
  logic              accept_p0;
  logic [7:0]        load_p0;
  logic [7:0]        drain_p0;
  logic [7:0]        vld_nxt_p0;
  logic [3:0]        cnt_nxt_p0;

`ifdef DEMUX_BCAST_EN
  assign bcast_p0 = in_bcast;
`else
  assign bcast_p0 = 1'b0;
`endif

  // ---- stage p0: acceptance, per-lane load/drain and next state ----
  // A lane is free if it is empty or is being drained this cycle. Since in_ready
  // depends only on registered valid flags and inputs, there is no path from
  // in_valid to out_valid within a cycle.
  always_comb begin
    free_p0    = ~vld_p1 | out_ready;
    in_ready   = en & rst_n & (bcast_p0 ? (&free_p0) : free_p0[in_sel]);
    accept_p0  = in_valid & in_ready;

    load_p0 = 8'd0;
    if (accept_p0) begin
      if (bcast_p0) begin
        load_p0 = 8'hFF;
      end else begin
        load_p0[in_sel] = 1'b1;
      end
    end

    drain_p0   = vld_p1 & out_ready;
    vld_nxt_p0 = load_p0 | (vld_p1 & ~drain_p0);

    // Loads into empty lanes add one. Loads into draining lanes leave the count
    // unchanged. Drains without a reload subtract one. A full block cannot
    // accept a load, so the count never goes past 8.
    cnt_nxt_p0 = cnt_p1 + popcnt8(load_p0 & ~vld_p1) - popcnt8(drain_p0 & ~load_p0);
  end

  // ---- stage p1: lane registers ----
  // Reset clears the data as well, so a reset mid-stream leaves no stale bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 8'd0;
      cnt_p1 <= 4'd0;
      for (int k = 0; k < LANES; k++) begin
        data_p1[k] <= '0;
      end
    end else begin
      vld_p1 <= vld_nxt_p0;
      cnt_p1 <= cnt_nxt_p0;
      for (int k = 0; k < LANES; k++) begin
        if (load_p0[k]) begin
          data_p1[k] <= in_data;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      out_data[k*DATA_W +: DATA_W] = data_p1[k];
    end
  end

  assign out_valid = vld_p1;
  assign out_cnt   = cnt_p1;

endmodule

// File: tb/tb_demux18_8b_buf.sv
// -----------------------------------------------------------------------------
// tb_demux18_8b_buf
//   Self-checking bench for demux18_8b_buf. It runs a directed vector table,
//   a broadcast sequence when DEMUX_BCAST_EN is defined, and a randomized
//   run. Every cycle is checked against a lane-array reference model.
// -----------------------------------------------------------------------------
module tb_demux18_8b_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_bcast;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [3:0]  out_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux18_8b_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
`ifdef DEMUX_BCAST_EN
    .in_bcast (in_bcast),
`endif
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cnt  (out_cnt)
  );

  // Reference model: eight lanes, each with an occupied flag and a byte.
  bit         m_full [8];
  logic [7:0] m_byte [8];

  function automatic bit m_ready();
    bit ok;
    if (!rst_n || !en) return 1'b0;
    if (in_bcast) begin
      ok = 1'b1;
      for (int k = 0; k < 8; k++) if (m_full[k] && !out_ready[k]) ok = 1'b0;
      return ok;
    end
    return !m_full[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic [7:0] m_vmask();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [63:0] m_dword();
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = m_byte[k];
    return w;
  endfunction

  function automatic logic [3:0] m_count();
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) if (m_full[k]) n++;
    return 4'(n);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive the inputs, check in_ready, clock the DUT, update
  // the model and check the registered outputs.
  task automatic step(input logic r, input logic e, input logic [7:0] d,
                      input logic [2:0] s, input logic v, input logic [7:0] o,
                      input logic bc, output logic rdy);
    bit acc;
    rst_n = r; en = e; in_data = d; in_sel = s; in_valid = v;
    out_ready = o; in_bcast = bc;
    #1;
    rdy = in_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready()});
    acc = v && m_ready();
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 8; k++) begin
        m_full[k] = 1'b0;
        m_byte[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 8; k++) if (m_full[k] && o[k]) m_full[k] = 1'b0;
      if (acc) begin
        for (int k = 0; k < 8; k++) begin
          if (bc || k == int'(s)) begin
            m_full[k] = 1'b1;
            m_byte[k] = d;
          end
        end
      end
    end
    #1;
    chk("out_valid", {56'd0, out_valid}, {56'd0, m_vmask()});
    chk("out_data",  out_data, m_dword());
    chk("out_cnt",   {60'd0, out_cnt}, {60'd0, m_count()});
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] d;
    logic [2:0] s;
    logic       v;
    logic [7:0] o;
    logic       x_rdy;
    logic [7:0] x_vld;
    logic [3:0] x_cnt;
    logic [7:0] x_l3;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic rdy;
    rst_n = 1'b0; en = 1'b0; in_data = 8'h00; in_sel = 3'd0;
    in_valid = 1'b0; out_ready = 8'h00; in_bcast = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 1'b0;
      m_byte[k] = 8'h00;
    end

    //                r     e     d      s     v     o      rdy   vld    cnt   lane3
    tbl.push_back('{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 8'h00}); // reset
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 3'd3, 1'b1, 8'h00, 1'b1, 8'h08, 4'd1, 8'hA5}); // first beat
    tbl.push_back('{1'b1, 1'b1, 8'h5A, 3'd3, 1'b1, 8'h00, 1'b0, 8'h08, 4'd1, 8'hA5}); // lane 3 blocked
    tbl.push_back('{1'b1, 1'b1, 8'h11, 3'd5, 1'b1, 8'h00, 1'b1, 8'h28, 4'd2, 8'hA5}); // other lane ok
    tbl.push_back('{1'b1, 1'b1, 8'h3C, 3'd3, 1'b1, 8'h08, 1'b1, 8'h28, 4'd2, 8'h3C}); // drain+load
    tbl.push_back('{1'b1, 1'b1, 8'h20, 3'd0, 1'b1, 8'h00, 1'b1, 8'h29, 4'd3, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 8'h21, 3'd1, 1'b1, 8'h00, 1'b1, 8'h2B, 4'd4, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 8'h22, 3'd2, 1'b1, 8'h00, 1'b1, 8'h2F, 4'd5, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 8'h24, 3'd4, 1'b1, 8'h00, 1'b1, 8'h3F, 4'd6, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 8'h26, 3'd6, 1'b1, 8'h00, 1'b1, 8'h7F, 4'd7, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 8'h27, 3'd7, 1'b1, 8'h00, 1'b1, 8'hFF, 4'd8, 8'h3C}); // all full
    for (int s = 0; s < 8; s++)
      tbl.push_back('{1'b1, 1'b1, 8'hEE, 3'(s), 1'b1, 8'h00, 1'b0, 8'hFF, 4'd8, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 8'h01, 1'b0, 8'hFE, 4'd7, 8'h3C}); // drain lane 0
    tbl.push_back('{1'b1, 1'b0, 8'h55, 3'd0, 1'b1, 8'h06, 1'b0, 8'hF8, 4'd5, 8'h3C}); // en=0 drains
    tbl.push_back('{1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 8'h08, 1'b1, 8'hF0, 4'd4, 8'h3C}); // 4 lanes full
    tbl.push_back('{1'b0, 1'b1, 8'h99, 3'd0, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 8'h00}); // reset mid-run
    tbl.push_back('{1'b1, 1'b1, 8'h42, 3'd3, 1'b1, 8'h00, 1'b1, 8'h08, 4'd1, 8'h42}); // first cycle out

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].o, 1'b0, rdy);
      chk($sformatf("tbl%0d_ready", i), {63'd0, rdy}, {63'd0, tbl[i].x_rdy});
      chk($sformatf("tbl%0d_valid", i), {56'd0, out_valid}, {56'd0, tbl[i].x_vld});
      chk($sformatf("tbl%0d_cnt", i), {60'd0, out_cnt}, {60'd0, tbl[i].x_cnt});
      chk($sformatf("tbl%0d_lane3", i), {56'd0, out_data[31:24]}, {56'd0, tbl[i].x_l3});
    end

    // Reset leaves no byte behind in a lane that was full before it.
    chk("rst_lane5_cleared", {56'd0, out_data[47:40]}, 64'd0);

`ifdef DEMUX_BCAST_EN
    step(1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, rdy);
    step(1'b1, 1'b1, 8'h77, 3'd2, 1'b1, 8'h00, 1'b1, rdy);
    chk("bcast_ready", {63'd0, rdy}, 64'd1);
    chk("bcast_data", out_data, 64'h7777_7777_7777_7777);
    chk("bcast_cnt", {60'd0, out_cnt}, 64'd8);
    // A broadcast is refused while any lane stays full.
    step(1'b1, 1'b1, 8'h12, 3'd0, 1'b1, 8'hFE, 1'b1, rdy);
    chk("bcast_blocked", {63'd0, rdy}, 64'd0);
`endif

    // Randomized run, checked each cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       r, e, v, bc;
      logic [7:0] d, o;
      logic [2:0] s;
      r  = ($urandom_range(0, 63) != 0);
      e  = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      s  = 3'($urandom);
      o  = 8'($urandom & $urandom);
`ifdef DEMUX_BCAST_EN
      bc = ($urandom_range(0, 5) == 0);
`else
      bc = 1'b0;
`endif
      step(r, e, d, s, v, o, bc, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux18_8b_buf.md
DEMUX18_8B_BUF -- requirements
Module: demux18_8b_buf

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 en  input  1  global enable; when 0, no beat SHALL be accepted, but lanes SHALL still drain.
REQ-005 in_data  input  8  byte to distribute.
REQ-006 in_sel  input  3  destination lane index 0..7.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  beat accepted this cycle when in_valid=1 and in_ready=1.
REQ-009 out_data  output  64  lane k data on bits [8k+7:8k].
REQ-010 out_valid  output  8  bit k set when lane k holds an undelivered byte.
REQ-011 out_ready  input  8  bit k set when the lane-k consumer takes the byte this cycle.
REQ-012 out_cnt  output  4  number of lanes with out_valid set, range 0..8.

Function
REQ-013 Each lane SHALL be a one-entry buffer consisting of an 8-bit data register and a valid flag.
REQ-014 A lane SHALL drain on a cycle when out_valid[k]=1 and out_ready[k]=1.
REQ-015 in_ready SHALL be combinational: en & rst_n & (~out_valid[in_sel] | out_ready[in_sel]).
- A full lane that drains in the same cycle SHALL accept a new beat (full throughput per lane).
REQ-016 On accept, lane in_sel SHALL load in_data at the next edge and set out_valid[in_sel]=1, giving a latency of 1 cycle from accept to out_valid.
REQ-017 On a cycle with a simultaneous drain and load on the same lane, out_valid SHALL stay 1 and out_data SHALL take the new byte.
REQ-018 On drain without load, out_valid[k] SHALL clear at the next edge.
REQ-019 out_data lane k SHALL hold its last value while out_valid[k]=0, and SHALL remain stable while out_valid[k]=1 and the lane is not drained.
REQ-020 Lanes SHALL be independent: a full lane SHALL NOT block beats addressed to other lanes.
REQ-021 A beat presented with in_ready=0 SHALL NOT alter any state, and upstream holds it.
REQ-022 out_cnt SHALL be a registered counter updated by (loads into empty-or-draining lanes) minus (drains without reload), and SHALL always equal popcount(out_valid).
- It SHALL never wrap: 8 + load is impossible by REQ-015.
REQ-023 out_valid SHALL be independent of in_valid within a cycle (no combinational path), and out_ready SHALL affect in_ready only.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL force out_valid=0, out_data=0, and out_cnt=0.
REQ-025 in_ready SHALL be 0 whenever rst_n=0.
REQ-026 A reset asserted mid-operation SHALL discard all buffered bytes and any beat presented that cycle, with no partial load.
REQ-027 The first accept after reset SHALL be possible in the first cycle with rst_n=1.

Configuration
REQ-028 Macro DEMUX_BCAST_EN SHALL control broadcast mode.
- Defined: the block SHALL add input in_bcast (1 bit).
- When in_bcast=1, in_ready SHALL = en & rst_n & AND over k of (~out_valid[k] | out_ready[k]).
- On accept with in_bcast=1, all 8 lanes SHALL load in_data, and out_cnt SHALL become 8.
- in_sel SHALL be ignored when in_bcast=1.
- Not defined: the in_bcast port SHALL be absent, and behaviour SHALL be as with in_bcast=0.

Verification
REQ-029 The bench SHALL cover: reset, then in_data=0xA5, in_sel=3, in_valid=1, out_ready=0 -> in_ready=1, next cycle out_valid=0x08, out_data[31:24]=0xA5, out_cnt=1.
REQ-030 The bench SHALL cover: lane 3 full, out_ready=0, second beat to sel=3 -> in_ready=0 and the byte held; beat to sel=5 -> accepted, out_valid=0x28, out_cnt=2.
REQ-031 The bench SHALL cover: lane 3 full, out_ready[3]=1, beat 0x3C to sel=3 in the same cycle -> accepted, out_valid[3] stays 1, out_data[31:24]=0x3C, out_cnt unchanged.
REQ-032 The bench SHALL cover: all 8 lanes filled, out_ready=0 -> out_cnt=8 and in_ready=0 for every in_sel; drain lane 0 only -> out_cnt=7 next cycle.
REQ-033 The bench SHALL cover: en=0 with in_valid=1 -> in_ready=0 and no load, while full lanes with out_ready=1 still clear.
REQ-034 The bench SHALL cover: rst_n=0 for one cycle with 4 lanes full and a beat pending -> out_valid=0, out_data=0, out_cnt=0; with DEMUX_BCAST_EN, in_bcast=1 with 0x77 after reset -> all lanes 0x77, out_cnt=8.
